// File: rtl/sensor_hub_pkg.sv
// Shared types, constants and helpers for the multi-channel sensor hub.
// Readings are carried as value x 100 in ENC_W-bit unsigned words.
package sensor_hub_pkg;

  localparam int ENC_W   = 16;
  localparam int SCALE   = 100;
  localparam int DEC_MAX = 99;
  localparam int CH_W    = 4;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [ENC_W-1:0] hum;
    logic [ENC_W-1:0] temp;
  } rec_t;

  // int*100 + min(dec, 99); the worst case 255.99 -> 25599 fits ENC_W.
  function automatic logic [ENC_W-1:0] encode(input logic [7:0] int_part,
                                               input logic [7:0] dec_part);
    logic [7:0] dec_sat;
    dec_sat = (dec_part > 8'(DEC_MAX)) ? 8'(DEC_MAX) : dec_part;
    return ENC_W'(int_part) * ENC_W'(SCALE) + ENC_W'(dec_sat);
  endfunction

  // Channel index reached by stepping 'step' places past 'base', modulo n.
  function automatic int rr_wrap(input int base, input int step, input int n);
    int s;
    s = base + step;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/sensor_hub_if.sv
// Sensor-side inputs and the record stream toward the display path.
// The hub takes the slave view; the sensor/display side takes the master view.
interface sensor_hub_if #(
  parameter int NCH = 4
);
  import sensor_hub_pkg::*;

  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_error;
  logic [8*NCH-1:0] in_hum_int;
  logic [8*NCH-1:0] in_hum_dec;
  logic [8*NCH-1:0] in_temp_int;
  logic [8*NCH-1:0] in_temp_dec;

  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [ENC_W-1:0] out_hum;
  logic [ENC_W-1:0] out_temp;
  logic [NCH-1:0]   ch_ok;

  modport master (
    output in_valid, in_error, in_hum_int, in_hum_dec, in_temp_int, in_temp_dec,
    output out_ready,
    input  out_valid, out_ch, out_hum, out_temp, ch_ok
  );

  modport slave (
    input  in_valid, in_error, in_hum_int, in_hum_dec, in_temp_int, in_temp_dec,
    input  out_ready,
    output out_valid, out_ch, out_hum, out_temp, ch_ok
  );
endinterface

// File: rtl/sensor_hub_channel.sv
// One sensor channel: encode, moving-average window, health timer and the
// pending flag that asks the arbiter to send the fresh average.
module sensor_hub_channel
  import sensor_hub_pkg::*;
#(
  parameter int AVG_LOG2     = 2,
  parameter int STALE_CYCLES = 300_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_error,
  input  logic [7:0]       hum_int,
  input  logic [7:0]       hum_dec,
  input  logic [7:0]       temp_int,
  input  logic [7:0]       temp_dec,
  input  logic             capture,
  output logic [ENC_W-1:0] avg_hum,
  output logic [ENC_W-1:0] avg_temp,
  output logic             pend,
  output logic             ok
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W = ENC_W + AVG_LOG2;
  localparam int CNT_W = $clog2(STALE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALE_LIM = CNT_W'(STALE_CYCLES);

  logic             good;
  logic [ENC_W-1:0] enc_hum, enc_temp;
  logic [ENC_W-1:0] hum_buf_q [DEPTH];
  logic [ENC_W-1:0] hum_buf_d [DEPTH];
  logic [ENC_W-1:0] temp_buf_q [DEPTH];
  logic [ENC_W-1:0] temp_buf_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [SUM_W-1:0] hum_sum_q, hum_sum_d, temp_sum_q, temp_sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d, pend_q, pend_d, ok_q, ok_d;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    hum_buf_d  = hum_buf_q;
    temp_buf_d = temp_buf_q;
    ptr_d      = ptr_q;
    hum_sum_d  = hum_sum_q;
    temp_sum_d = temp_sum_q;
    primed_d   = primed_q;
    cnt_d      = cnt_q;
    ok_d       = ok_q;

    good     = in_valid && !in_error;
    enc_hum  = encode(hum_int, hum_dec);
    enc_temp = encode(temp_int, temp_dec);

    if (good) begin
      if (!primed_q) begin
        // First sample fills the whole window so the average is exact at once.
        for (int i = 0; i < DEPTH; i++) begin
          hum_buf_d[i]  = enc_hum;
          temp_buf_d[i] = enc_temp;
        end
        hum_sum_d  = SUM_W'(enc_hum) << AVG_LOG2;
        temp_sum_d = SUM_W'(enc_temp) << AVG_LOG2;
        ptr_d      = '0;
        primed_d   = 1'b1;
      end else begin
        hum_sum_d         = hum_sum_q - SUM_W'(hum_buf_q[ptr_q]) + SUM_W'(enc_hum);
        temp_sum_d        = temp_sum_q - SUM_W'(temp_buf_q[ptr_q]) + SUM_W'(enc_temp);
        hum_buf_d[ptr_q]  = enc_hum;
        temp_buf_d[ptr_q] = enc_temp;
        ptr_d             = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      end
    end

    if (good)                  cnt_d = '0;
    else if (cnt_q != STALE_LIM) cnt_d = cnt_q + 1'b1;

    if (in_error)                ok_d = 1'b0;
    else if (good)               ok_d = 1'b1;
    else if (cnt_d == STALE_LIM) ok_d = 1'b0;

    // A sample landing on the capture edge must be sent again: set wins.
    pend_d = (pend_q && !capture) || good;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge _d values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      hum_sum_q  <= '0;
      temp_sum_q <= '0;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      pend_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      hum_sum_q  <= hum_sum_d;
      temp_sum_q <= temp_sum_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      pend_q     <= pend_d;
      ok_q       <= ok_d;
    end
  end

  // NOTE: window storage has no reset; primed_q forces a prefill on the first
  // sample after reset, so old contents are never read.
  always_ff @(posedge clk) begin
    hum_buf_q  <= hum_buf_d;
    temp_buf_q <= temp_buf_d;
  end

  assign avg_hum  = hum_sum_q[AVG_LOG2 +: ENC_W];
  assign avg_temp = temp_sum_q[AVG_LOG2 +: ENC_W];
  assign pend     = pend_q;
  assign ok       = ok_q;

endmodule

// File: rtl/sensor_hub.sv
// Multi-channel sensor hub: per-channel averaging plus a round-robin arbiter
// that serialises fresh averages onto one valid/ready record stream.
module sensor_hub
  import sensor_hub_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int AVG_LOG2     = 2,
  parameter int STALE_CYCLES = 300_000_000
) (
  input logic       clk,
  input logic       reset,
  sensor_hub_if.slave bus
);

  logic [ENC_W-1:0] avg_hum  [NCH];
  logic [ENC_W-1:0] avg_temp [NCH];
  logic [NCH-1:0]   pend, ok, capture_vec;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    sensor_hub_channel #(
      .AVG_LOG2    (AVG_LOG2),
      .STALE_CYCLES(STALE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .in_valid(bus.in_valid[c]),
      .in_error(bus.in_error[c]),
      .hum_int (bus.in_hum_int[8*c +: 8]),
      .hum_dec (bus.in_hum_dec[8*c +: 8]),
      .temp_int(bus.in_temp_int[8*c +: 8]),
      .temp_dec(bus.in_temp_dec[8*c +: 8]),
      .capture (capture_vec[c]),
      .avg_hum (avg_hum[c]),
      .avg_temp(avg_temp[c]),
      .pend    (pend[c]),
      .ok      (ok[c])
    );
  end

  rec_t             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  last_q, last_d, grant;
  logic [ENC_W-1:0] sel_hum, sel_temp;
  logic             found, capture;

  always_comb begin
    grant    = '0;
    sel_hum  = '0;
    sel_temp = '0;
    found    = 1'b0;
    // Walk furthest-first so the channel nearest after last_q is kept.
    for (int i = NCH; i >= 1; i--) begin
      for (int j = 0; j < NCH; j++) begin
        if (pend[j] && (j == rr_wrap(int'(last_q), i, NCH))) begin
          grant    = CH_W'(j);
          sel_hum  = avg_hum[j];
          sel_temp = avg_temp[j];
          found    = 1'b1;
        end
      end
    end

    capture     = found && (!out_valid_q || bus.out_ready);
    capture_vec = capture ? (NCH'(1) << grant) : '0;

    out_d       = out_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (capture) begin
      out_d.ch    = grant;
      out_d.hum   = sel_hum;
      out_d.temp  = sel_temp;
      out_valid_d = 1'b1;
      last_d      = grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= CH_W'(NCH - 1);
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_q.ch;
  assign bus.out_hum   = out_q.hum;
  assign bus.out_temp  = out_q.temp;
  assign bus.ch_ok     = ok;

endmodule
